// File: rtl/roi_scan_pkg.sv
// roi_scan_pkg: shared types and constants for the ROI scan driver.
// Optional CRC hardware is enabled with the ROI_SCAN_CRC_EN macro.
package roi_scan_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        CAPT   = 3'd4,
        UNLOAD = 3'd5,
        DONE   = 3'd6
    } roi_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Largest of three widths/counts, used to size the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One MSB-first CRC-16-CCITT step for a single input bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/roi_scan_if.sv
// roi_scan_if: serial connection between the scan driver and the ROI
// harness shift chain (di in, do out, stb load/capture strobe).
interface roi_scan_if;
    logic di;
    logic stb;
    logic do_in;

    modport master (output di, output stb, input do_in);
    modport slave  (input di, input stb, output do_in);
endinterface

// File: rtl/roi_scan_crc16.sv
// roi_scan_crc16: serial CRC-16-CCITT, one bit per enabled cycle, MSB first.
// Only instantiated by the driver when ROI_SCAN_CRC_EN is defined.
module roi_scan_crc16
    import roi_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    // Re-seed on init, otherwise fold in one bit whenever en is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= CRC16_INIT;
        end else if (init) begin
            crc_q <= CRC16_INIT;
        end else if (en) begin
            crc_q <= crc16_step(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/roi_scan_driver.sv
// roi_scan_driver: shifts a stimulus into the ROI harness, strobes load,
// waits SETTLE_CYC cycles, strobes capture and shifts the response back.
// Define ROI_SCAN_CRC_EN to add a CRC-16 over the unloaded response bits.
module roi_scan_driver
    import roi_scan_pkg::*;
#(
    parameter int DIN_N      = 256,
    parameter int DOUT_N     = 256,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIN_N-1:0]  load_data,
    roi_scan_if.master        scan,
    output logic              busy,
    output logic              done,
    output logic [DOUT_N-1:0] capture_data,
    output logic [15:0]       crc
);

    localparam int CNT_W = $clog2(max3(DIN_N, DOUT_N, SETTLE_CYC) + 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_SHIFT  = SHIFT;
    localparam logic [2:0] ST_LOAD   = LOAD;
    localparam logic [2:0] ST_SETTLE = SETTLE;
    localparam logic [2:0] ST_CAPT   = CAPT;
    localparam logic [2:0] ST_UNLOAD = UNLOAD;
    localparam logic [2:0] ST_DONE   = DONE;

    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(DIN_N - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(DOUT_N - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIN_N-1:0]  din_q, din_d;
    logic [DOUT_N-1:0] sr_q, sr_d;
    logic              di_q, di_d;
    logic              stb_q, busy_q, done_q;
    logic [DOUT_N-1:0] cap_q;

    // Next-state logic: the stimulus register shifts left so its MSB is always
    // the bit to drive, and the response register shifts do_in in at the LSB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        sr_d    = sr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    din_d   = load_data;
                end
            end
            ST_SHIFT: begin
                din_d = din_q << 1;
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CAPT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPT: begin
                state_d = ST_UNLOAD;
                cnt_d   = '0;
            end
            ST_UNLOAD: begin
                sr_d = (sr_q << 1) | {{(DOUT_N-1){1'b0}}, scan.do_in};
                if (cnt_q == UNLOAD_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        di_d = (state_d == ST_SHIFT) ? din_d[DIN_N-1] : 1'b0;
    end

    // State and registered outputs, all decoded from the next state so each
    // output lines up with the cycle its state is actually occupied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            din_q   <= '0;
            sr_q    <= '0;
            di_q    <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            sr_q    <= sr_d;
            di_q    <= di_d;
            stb_q   <= (state_d == ST_LOAD) || (state_d == ST_CAPT);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                cap_q <= sr_d;
            end
        end
    end

    assign scan.di      = di_q;
    assign scan.stb     = stb_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign capture_data = cap_q;

`ifdef ROI_SCAN_CRC_EN
    logic crc_init;
    logic crc_en;

    assign crc_init = (state_q == ST_IDLE) && start;
    assign crc_en   = (state_q == ST_UNLOAD);

    roi_scan_crc16 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .init   (crc_init),
        .en     (crc_en),
        .bit_in (scan.do_in),
        .crc    (crc)
    );
`else
    assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_roi_scan_driver.sv
// tb_roi_scan_driver: directed bench for roi_scan_driver with a model ROI
// harness (din/dout shift chains, ROI output = registered ~din).
module tb_roi_scan_driver;

    localparam int DIN_N      = 256;
    localparam int DOUT_N     = 256;
    localparam int SETTLE_CYC = 4;
    localparam int DONE_CYC   = DIN_N + 1 + SETTLE_CYC + 1 + DOUT_N;
    localparam int LOAD_CYC   = DIN_N;

`ifdef ROI_SCAN_CRC_EN
    localparam logic [15:0] CRC_RESET = 16'hFFFF;
`else
    localparam logic [15:0] CRC_RESET = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DIN_N-1:0]  load_data = '0;
    logic              busy;
    logic              done;
    logic [DOUT_N-1:0] capture_data;
    logic [15:0]       crc;

    roi_scan_if scanIf ();

    roi_scan_driver #(
        .DIN_N      (DIN_N),
        .DOUT_N     (DOUT_N),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .load_data    (load_data),
        .scan         (scanIf),
        .busy         (busy),
        .done         (done),
        .capture_data (capture_data),
        .crc          (crc)
    );

    // 10 ns clock shared by the driver and the harness model.
    always #5 clk = ~clk;

    logic [DIN_N-1:0]  dinShr  = '0;
    logic [DIN_N-1:0]  dinRoi  = '0;
    logic [DOUT_N-1:0] doutRoi = '0;
    logic [DOUT_N-1:0] doutShr = '0;

    // Harness model: stb loads din into the ROI and captures the ROI output,
    // otherwise both chains shift by one bit.
    always @(posedge clk) begin
        if (scanIf.stb) begin
            dinRoi  <= dinShr;
            doutShr <= doutRoi;
        end else begin
            dinShr  <= {dinShr[DIN_N-2:0], scanIf.di};
            doutShr <= {doutShr[DOUT_N-2:0], 1'b0};
        end
        doutRoi <= ~dinRoi;
    end

    assign scanIf.do_in = doutShr[DOUT_N-1];

    int checks = 0;
    int errors = 0;

    int doneAt, stbCnt, stbFirst, stbLast, diCnt, diLast, busyLowCnt;

    // Reference CRC-16-CCITT over the response in unload order (MSB first).
    function automatic logic [15:0] refCrc(input logic [DOUT_N-1:0] resp);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = DOUT_N - 1; i >= 0; i--) begin
            fb = c[15] ^ resp[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a scan and follow it cycle by cycle until done (bounded).
    // Cycle m=0 is the first cycle after the accepting edge. Extra start
    // pulses are raised during cycles pulseA/pulseB; load_data is swapped
    // to dataAfter right after acceptance.
    task automatic applyStimulus(input logic [DIN_N-1:0] data, input int pulseA,
                                 input int pulseB, input logic [DIN_N-1:0] dataAfter);
        doneAt = -1; stbCnt = 0; stbFirst = -1; stbLast = -1;
        diCnt = 0; diLast = -1; busyLowCnt = 0;
        load_data = data;
        start = 1'b1;
        tick();
        load_data = dataAfter;
        start = 1'b0;
        for (int m = 0; m < 700 && doneAt < 0; m++) begin
            if (scanIf.stb) begin
                if (stbCnt == 0) stbFirst = m;
                stbLast = m;
                stbCnt++;
            end
            if (scanIf.di) begin
                diCnt++;
                diLast = m;
            end
            if (!busy) busyLowCnt++;
            if (done) doneAt = m;
            start = (m == pulseA) || (m == pulseB);
            if (doneAt < 0) tick();
        end
        start = 1'b0;
    endtask

    logic [DIN_N-1:0] pat;
    int stbAfterReset;

    initial begin
        $display("[TB] roi_scan_driver directed test");

        // T1: reset held for three cycles.
        rst_n = 1'b0;
        tick(); tick(); tick();
        checkOutput("rst_di",   256'(scanIf.di),  256'(0));
        checkOutput("rst_stb",  256'(scanIf.stb), 256'(0));
        checkOutput("rst_busy", 256'(busy),       256'(0));
        checkOutput("rst_done", 256'(done),       256'(0));
        checkOutput("rst_cap",  capture_data,     256'(0));
        checkOutput("rst_crc",  256'(crc),        256'(CRC_RESET));
        rst_n = 1'b1;
        tick();

        // T2: alternating stimulus; load_data changes after start must not matter.
        pat = {128{2'b10}};
        applyStimulus(pat, -1, -1, '0);
        checkOutput("t2_done_cycle", 256'(doneAt),  256'(DONE_CYC));
        checkOutput("t2_stb_count",  256'(stbCnt),  256'(2));
        checkOutput("t2_stb_first",  256'(stbFirst), 256'(LOAD_CYC));
        checkOutput("t2_stb_gap",    256'(stbLast - stbFirst), 256'(SETTLE_CYC + 1));
        checkOutput("t2_busy_gap",   256'(busyLowCnt), 256'(0));
        checkOutput("t2_capture",    capture_data, {128{2'b01}});
`ifdef ROI_SCAN_CRC_EN
        checkOutput("t2_crc", 256'(crc), 256'(refCrc({128{2'b01}})));
`else
        checkOutput("t2_crc", 256'(crc), 256'(0));
`endif
        tick();
        checkOutput("t2_done_pulse", 256'(done), 256'(0));

        // T3: only the LSB set, so di is high only in the last SHIFT cycle.
        applyStimulus(256'h1, -1, -1, 256'h1);
        checkOutput("t3_di_count", 256'(diCnt),  256'(1));
        checkOutput("t3_di_cycle", 256'(diLast), 256'(DIN_N - 1));
        checkOutput("t3_capture",  capture_data, ~256'h1);
        tick();

        // T4: starts while busy are dropped; DONE-cycle start ignored,
        // start in the following cycle accepted.
        pat = {8{32'hDEADBEEF}};
        applyStimulus(pat, 10, 300, pat);
        checkOutput("t4_done_cycle", 256'(doneAt), 256'(DONE_CYC));
        checkOutput("t4_stb_count",  256'(stbCnt), 256'(2));
        checkOutput("t4_capture",    capture_data, ~pat);
        start = 1'b1;
        tick();
        checkOutput("t4_idle_busy", 256'(busy), 256'(0));
        checkOutput("t4_idle_done", 256'(done), 256'(0));
        tick();
        start = 1'b0;
        checkOutput("t4_restart_busy", 256'(busy), 256'(1));

        // T5: reset during UNLOAD cycle 100 of the restarted scan.
        for (int i = 0; i < DIN_N + 1 + SETTLE_CYC + 1 + 100; i++) tick();
        checkOutput("t5_busy_before", 256'(busy), 256'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t5_busy", 256'(busy),       256'(0));
        checkOutput("t5_stb",  256'(scanIf.stb), 256'(0));
        checkOutput("t5_di",   256'(scanIf.di),  256'(0));
        checkOutput("t5_done", 256'(done),       256'(0));
        checkOutput("t5_cap",  capture_data,     256'(0));
        checkOutput("t5_crc",  256'(crc),        256'(CRC_RESET));
        stbAfterReset = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (scanIf.stb) stbAfterReset++;
        end
        checkOutput("t5_no_stb", 256'(stbAfterReset), 256'(0));
        applyStimulus('0, -1, -1, '0);
        checkOutput("t5_rescan_done", 256'(doneAt), 256'(DONE_CYC));
        checkOutput("t5_rescan_cap",  capture_data, ~256'h0);
        tick();

        // T6: all-ones stimulus gives an all-zero response for the CRC check.
        applyStimulus(~256'h0, -1, -1, ~256'h0);
        checkOutput("t6_capture", capture_data, 256'(0));
`ifdef ROI_SCAN_CRC_EN
        checkOutput("t6_crc", 256'(crc), 256'(refCrc('0)));
`else
        checkOutput("t6_crc", 256'(crc), 256'(0));
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
